mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide beside the EX-stage ALU.
// Ports: clk/reset_n, start/op/A/B/abort in; busy/done/result/overflow/div_by_zero out.
module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             neg_q;
  logic             sa_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] ovf_q;
  logic             dbz_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   mul_hi;
  logic [WIDTH-1:0]   mul_lo;
  logic [WIDTH:0]     dshift;
  logic [WIDTH:0]     ddiff;
  logic               qbit;
  logic [WIDTH-1:0]   div_hi;
  logic [WIDTH-1:0]   div_lo;
  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_fin;
  logic [WIDTH-1:0]   ovf_fin;
  logic               last;

  always_comb begin
    a_mag = A[WIDTH-1] ? -A : A;
    b_mag = B[WIDTH-1] ? -B : B;

    // Multiply: {hi,lo} shifts right; lo starts as the multiplier.
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi = msum[WIDTH:1];
    mul_lo = {msum[0], lo_q[WIDTH-1:1]};

    // Divide: lo starts as the dividend and fills with quotient bits.
    // The remainder stays below the divisor, so dshift never exceeds WIDTH bits
    // and ddiff's top bit is the borrow.
    dshift = {hi_q, lo_q[WIDTH-1]};
    ddiff  = dshift - {1'b0, opnd_q};
    qbit   = ~ddiff[WIDTH];
    div_hi = qbit ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
    div_lo = {lo_q[WIDTH-2:0], qbit};

    it_hi = op_q ? div_hi : mul_hi;
    it_lo = op_q ? div_lo : mul_lo;

    prod     = {it_hi, it_lo};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -it_lo : it_lo;
    rem_fix  = sa_q ? -it_hi : it_hi;

    res_fin = op_q ? quot_fix : prod_fix[WIDTH-1:0];
    ovf_fin = op_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];

    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            if (op && (B == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= '1;
              ovf_q   <= A;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
              op_q    <= op;
              sa_q    <= A[WIDTH-1];
              neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
              cnt_q   <= '0;
              hi_q    <= '0;
              // Multiplicand or divisor is kept fixed; lo shifts.
              opnd_q  <= op ? b_mag : a_mag;
              lo_q    <= op ? a_mag : b_mag;
            end
          end
        end
        S_BUSY: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= it_hi;
            lo_q  <= it_lo;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              res_q   <= res_fin;
              ovf_q   <= ovf_fin;
              dbz_q   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = res_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Cycle-accurate busy/done timing, results, abort and async reset.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [15:0] A;
  logic [15:0] B;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] overflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start in cycle 0, busy in 1..16, done with results in 17, idle in 18.
  task automatic run_op(input string tag, input logic o,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic [15:0] eo);
    int bad;
    op = o; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0; A = 16'hDEAD; B = 16'hBEEF;
    bad = 0;
    for (int c = 1; c <= 16; c++) begin
      if (!(busy === 1'b1 && done === 1'b0)) bad++;
      step();
    end
    chk({tag, "_busy1to16"}, 32'(bad), 32'd0);
    chk({tag, "_done17"}, {30'd0, busy, done}, 32'b01);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
    chk({tag, "_overflow"}, {16'd0, overflow}, {16'd0, eo});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    step();
    chk({tag, "_idle18"}, {30'd0, busy, done}, 32'b00);
  endtask

  initial begin
    int bad;
    reset_n = 1'b0; start = 1'b0; op = 1'b0;
    A = '0; B = '0; abort = 1'b0;
    #12;
    chk("reset_outs", {busy, done, div_by_zero, 13'd0, result},
        32'd0);
    chk("reset_ovf", {16'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    step();

    run_op("mul_3_m5", 1'b0, 16'd3, 16'hFFFB, 16'hFFF1, 16'hFFFF);
    run_op("mul_7fff", 1'b0, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF);
    run_op("mul_8000", 1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h4000);
    run_op("div_m7_2", 1'b1, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF);
    run_op("div_min_m1", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);

    // Divide by zero: done in cycle 1, busy never asserted.
    op = 1'b1; A = 16'h1234; B = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("dbz_c1", {30'd0, busy, done}, 32'b01);
    chk("dbz_result", {16'd0, result}, 32'h0000FFFF);
    chk("dbz_overflow", {16'd0, overflow}, 32'h00001234);
    chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    step();
    chk("dbz_c2", {30'd0, busy, done}, 32'b00);
    chk("dbz_hold", {15'd0, div_by_zero, result}, 32'h0001FFFF);

    run_op("div_100_7", 1'b1, 16'd100, 16'd7, 16'd14, 16'd2);

    // Abort in cycle 5 of a multiply.
    op = 1'b0; A = 16'd3; B = 16'hFFFB; start = 1'b1;
    step();
    start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 4; c++) begin
      if (done !== 1'b0) bad++;
      step();
    end
    chk("abort_nodone", 32'(bad), 32'd0);
    chk("abort_c5_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_c6", {30'd0, busy, done}, 32'b00);
    chk("abort_keep", {div_by_zero, 15'd0, result}, 32'd14);
    chk("abort_keep_ovf", {16'd0, overflow}, 32'd2);
    run_op("after_abort", 1'b0, 16'd3, 16'hFFFB, 16'hFFF1, 16'hFFFF);

    // abort with start in IDLE: nothing starts.
    op = 1'b1; A = 16'd9; B = 16'd0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    bad = 0;
    for (int c = 1; c <= 3; c++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad++;
      step();
    end
    chk("abort_idle", 32'(bad), 32'd0);
    chk("abort_idle_keep", {div_by_zero, 15'd0, result}, 32'h0000FFF1);

    // Asynchronous reset in cycle 9 of a divide.
    op = 1'b1; A = 16'd100; B = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) step();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid", {busy, done, div_by_zero, 13'd0, result}, 32'd0);
    chk("reset_mid_ovf", {16'd0, overflow}, 32'd0);
    #2;
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", {30'd0, busy, done}, 32'b00);
    run_op("post_reset", 1'b0, 16'd3, 16'hFFFB, 16'hFFF1, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
